rom_lut_reader: RTL and testbench

- Request-side front end for the dual-port lookup ROM. Sits directly upstream of one ROM read port and drives its address.
- Accepts tagged lookup requests through a valid/ready handshake and tracks the ROM's fixed read latency with a valid/tag delay line.
- Captures the returned words into a small first-word-fall-through output FIFO. This gives the non-stallable ROM pipeline a back-pressurable ready/valid output stream.

---
 rtl/rom_lut_reader.sv | 155 +++++++++++++++
 tb/tb_rom_lut_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_lut_reader.sv
// rom_lut_reader
// Request-side front end for one read port of the dual-port lookup ROM.
// Tagged lookups are accepted over a valid/ready handshake. Each accepted
// address goes straight to the ROM. A valid/tag delay line follows the ROM's
// fixed read latency, and returned words land in a small first-word-fall-
// through FIFO, so the non-stallable ROM pipeline feeds a back-pressurable
// output stream.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_valid/in_ready    request handshake
//   in_addr, in_tag      lookup address and opaque tag
//   rom_addr, rom_data   ROM read port (address is a combinational copy)
//   out_valid/out_ready  result handshake
//   out_data, out_tag    head-of-FIFO word and its tag (zero when empty)
//   fifo_count           output FIFO occupancy
//   ovf_err              sticky flag: FIFO written while full without a pop
module rom_lut_reader #(
    parameter int MXADRB      = 12,
    parameter int MXDATB      = 9,
    parameter int TAGB        = 8,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int PTRB = $clog2(FIFO_DEPTH),
    localparam int CNTB = PTRB + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MXADRB-1:0] in_addr,
    input  logic [TAGB-1:0]   in_tag,
    output logic [MXADRB-1:0] rom_addr,
    input  logic [MXDATB-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MXDATB-1:0] out_data,
    output logic [TAGB-1:0]   out_tag,
    output logic [CNTB-1:0]   fifo_count,
    output logic              ovf_err
);

    localparam int SUMB = CNTB + 1;

    logic [ROM_LATENCY-1:0]           v_q, v_d;
    logic [ROM_LATENCY-1:0][TAGB-1:0] tag_q, tag_d;

    logic [MXDATB-1:0] data_mem_q [FIFO_DEPTH];
    logic [MXDATB-1:0] data_mem_d [FIFO_DEPTH];
    logic [TAGB-1:0]   tag_mem_q  [FIFO_DEPTH];
    logic [TAGB-1:0]   tag_mem_d  [FIFO_DEPTH];

    logic [CNTB-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNTB-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTB-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [SUMB-1:0] credit_used;
    logic            acc;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic [PTRB-1:0] rd_idx;
    logic [PTRB-1:0] wr_idx;

    // Credit check, handshakes and FIFO status. Everything here depends only
    // on registered state, so a pop in this cycle cannot raise in_ready. That
    // keeps room for every lookup still travelling through the ROM.
    always_comb begin
        credit_used = SUMB'(count_q);
        for (int i = 0; i < ROM_LATENCY; i++) begin
            credit_used = credit_used + SUMB'(v_q[i]);
        end
        in_ready  = !rst && (credit_used < SUMB'(FIFO_DEPTH));
        acc       = in_valid && in_ready;
        rom_addr  = in_addr;

        full      = (count_q == CNTB'(FIFO_DEPTH));
        empty     = (count_q == '0);
        out_valid = !rst && !empty;
        pop       = out_valid && out_ready;
        push      = v_q[ROM_LATENCY-1];
        // A write into a full FIFO with no pop is dropped and flagged.
        wr_en     = push && (!full || pop);

        rd_idx    = rd_ptr_q[PTRB-1:0];
        wr_idx    = wr_ptr_q[PTRB-1:0];
        out_data  = out_valid ? data_mem_q[rd_idx] : '0;
        out_tag   = out_valid ? tag_mem_q[rd_idx]  : '0;

        fifo_count = count_q;
        ovf_err    = ovf_q;
    end

    // Next state for the delay line, FIFO storage, pointers, count and the
    // sticky overflow flag.
    always_comb begin
        v_d      = v_q;
        tag_d    = tag_q;
        v_d[0]   = acc;
        tag_d[0] = in_tag;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            v_d[i]   = v_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        data_mem_d = data_mem_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (wr_en) begin
            data_mem_d[wr_idx] = rom_data;
            tag_mem_d[wr_idx]  = tag_q[ROM_LATENCY-1];
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q || (push && full && !pop);
    end

    // State registers. Clearing the delay-line valids on reset means ROM data
    // still in flight is never captured afterwards. The storage array does
    // not need clearing because the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            v_q      <= v_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
        data_mem_q <= data_mem_d;
        tag_mem_q  <= tag_mem_d;
    end

endmodule

// File: tb/tb_rom_lut_reader.sv
// Testbench for rom_lut_reader: a registered two-cycle ROM model plus
// directed scenarios and a randomized scoreboard run.
module tb_rom_lut_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_addr;
    logic [7:0]  in_tag;
    logic [11:0] rom_addr;
    logic [8:0]  rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_data;
    logic [7:0]  out_tag;
    logic [2:0]  fifo_count;
    logic        ovf_err;

    int compared   = 0;
    int mismatched = 0;

    rom_lut_reader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_tag     (in_tag),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .fifo_count (fifo_count),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    // ROM contents: word 5 holds 0x1A3, everything else is a scrambled address.
    function automatic logic [8:0] rom_fn(input logic [11:0] a);
        logic [11:0] t;
        if (a == 12'h005) return 9'h1A3;
        t = (a * 12'd37) ^ 12'h0B5;
        return t[8:0];
    endfunction

    // Registered ROM with two edges from address sample to valid data.
    logic [8:0] rom_stage;
    always @(posedge clk) begin
        rom_stage <= rom_fn(rom_addr);
        rom_data  <= rom_stage;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_addr = 12'h005; in_tag = 8'h11;
        repeat (3) tick();
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        compared++;
        if (out_data !== 9'h0 || out_tag !== 8'h0) begin mismatched++; $display("[TB] FAIL reset_out_zero got data %h tag %h want 0/0", out_data, out_tag); end
        compared++;
        if (fifo_count !== 3'd0 || ovf_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_count_ovf got %0d/%b want 0/0", fifo_count, ovf_err); end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 1'b1; in_addr = 12'h005; in_tag = 8'h11;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL single_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early1 got %b want 0", out_valid); end
        tick();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early2 got %b want 0", out_valid); end
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_data !== 9'h1A3 || out_tag !== 8'h11 || fifo_count !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL single_result got v=%b d=%h t=%h c=%0d want 1/1a3/11/1", out_valid, out_data, out_tag, fifo_count);
        end
        tick();
        compared++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_popped got c=%0d v=%b want 0/0", fifo_count, out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int c = 0; c < 68; c++) begin
            in_valid = (c < 64);
            in_addr  = 12'(c);
            in_tag   = 8'(c);
            if (c < 64) begin
                compared++;
                if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_ready[%0d] got %b want 1", c, in_ready); end
            end
            tick();
            compared++;
            if (out_valid !== (c >= 2 && c <= 65)) begin
                mismatched++;
                $display("[TB] FAIL stream_valid[%0d] got %b want %b", c, out_valid, (c >= 2 && c <= 65));
            end else if (c >= 2 && c <= 65) begin
                compared++;
                if (out_tag !== 8'(c - 2) || out_data !== rom_fn(12'(c - 2))) begin
                    mismatched++;
                    $display("[TB] FAIL stream_word[%0d] got %h/%h want %h/%h", c - 2, out_tag, out_data, 8'(c - 2), rom_fn(12'(c - 2)));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        int accepts = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_addr  = 12'h100 + 12'(accepts);
            in_tag   = 8'h80 + 8'(accepts);
            if (in_ready) accepts++;
            tick();
        end
        compared++;
        if (accepts != 4) begin mismatched++; $display("[TB] FAIL bp_accepts got %0d want 4", accepts); end
        compared++;
        if (in_ready !== 1'b0 || fifo_count !== 3'd4 || ovf_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_full got r=%b c=%0d ovf=%b want 0/4/0", in_ready, fifo_count, ovf_err);
        end
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (out_valid !== 1'b1 || out_tag !== 8'h80 || out_data !== rom_fn(12'h100)) begin
                mismatched++;
                $display("[TB] FAIL bp_stable[%0d] got v=%b t=%h d=%h want 1/80/%h", c, out_valid, out_tag, out_data, rom_fn(12'h100));
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (out_valid !== 1'b1 || out_tag !== 8'h80 + 8'(i) || out_data !== rom_fn(12'h100 + 12'(i))) begin
                mismatched++;
                $display("[TB] FAIL bp_drain[%0d] got v=%b t=%h d=%h want 1/%h/%h", i, out_valid, out_tag, out_data, 8'h80 + 8'(i), rom_fn(12'h100 + 12'(i)));
            end
            tick();
        end
        compared++;
        if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_recovered got c=%0d r=%b want 0/1", fifo_count, in_ready); end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        in_valid = 1'b1; in_addr = 12'h040; in_tag = 8'h40;
        tick();
        in_addr = 12'h041; in_tag = 8'h41;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_addr = 12'h042; in_tag = 8'h42;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        compared++;
        if (fifo_count !== 3'd2 || out_tag !== 8'h40) begin mismatched++; $display("[TB] FAIL pp_before got c=%0d t=%h want 2/40", fifo_count, out_tag); end
        tick();
        out_ready = 1'b0;
        compared++;
        if (fifo_count !== 3'd2 || out_tag !== 8'h41 || out_data !== rom_fn(12'h041)) begin
            mismatched++;
            $display("[TB] FAIL pp_after got c=%0d t=%h d=%h want 2/41/%h", fifo_count, out_tag, out_data, rom_fn(12'h041));
        end
        out_ready = 1'b1;
        tick();
        compared++;
        if (out_tag !== 8'h42 || out_data !== rom_fn(12'h042)) begin mismatched++; $display("[TB] FAIL pp_tail got t=%h d=%h want 42/%h", out_tag, out_data, rom_fn(12'h042)); end
        tick();
        compared++;
        if (fifo_count !== 3'd0) begin mismatched++; $display("[TB] FAIL pp_empty got c=%0d want 0", fifo_count); end
    endtask

    // The credit limit caps buffered plus in-flight at four, so this fills
    // two FIFO entries with two more lookups still inside the ROM.
    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = 12'h200 + 12'(i);
            in_tag   = 8'hC0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        compared++;
        if (fifo_count !== 3'd2) begin mismatched++; $display("[TB] FAIL mid_prefill got c=%0d want 2", fifo_count); end
        rst = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_tag !== 8'h0) begin
            mismatched++;
            $display("[TB] FAIL mid_during_rst got v=%b r=%b t=%h want 0/0/00", out_valid, in_ready, out_tag);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin mismatched++; $display("[TB] FAIL mid_after_rst got v=%b c=%0d want 0/0", out_valid, fifo_count); end
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin mismatched++; $display("[TB] FAIL mid_stale[%0d] got v=%b c=%0d want 0/0", c, out_valid, fifo_count); end
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_addr[$];
        logic [7:0]  exp_tag[$];
        logic [7:0]  seq = 8'h00;
        int          budget;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_addr   = 12'($urandom_range(0, 4095));
            in_tag    = seq;
            #1;
            if (out_valid && out_ready) begin
                compared++;
                if (exp_tag.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL rand_extra[%0d] got tag %h want none", c, out_tag);
                end else begin
                    if (out_tag !== exp_tag[0] || out_data !== rom_fn(exp_addr[0])) begin
                        mismatched++;
                        $display("[TB] FAIL rand_word[%0d] got %h/%h want %h/%h", c, out_tag, out_data, exp_tag[0], rom_fn(exp_addr[0]));
                    end
                    void'(exp_tag.pop_front());
                    void'(exp_addr.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_addr.push_back(in_addr);
                exp_tag.push_back(in_tag);
                seq = seq + 8'h01;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget = 50;
        while (exp_tag.size() != 0 && budget > 0) begin
            if (out_valid) begin
                compared++;
                if (out_tag !== exp_tag[0] || out_data !== rom_fn(exp_addr[0])) begin
                    mismatched++;
                    $display("[TB] FAIL rand_drain got %h/%h want %h/%h", out_tag, out_data, exp_tag[0], rom_fn(exp_addr[0]));
                end
                void'(exp_tag.pop_front());
                void'(exp_addr.pop_front());
            end
            tick();
            budget--;
        end
        compared++;
        if (exp_tag.size() != 0) begin mismatched++; $display("[TB] FAIL rand_missing got %0d left want 0", exp_tag.size()); end
        compared++;
        if (ovf_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rand_ovf got %b want 0", ovf_err); end
        tick();
        compared++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin mismatched++; $display("[TB] FAIL rand_leftover got v=%b c=%0d want 0/0", out_valid, fifo_count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_addr = '0; in_tag = '0;
        test_reset();
        test_single();
        idle(4);
        test_streaming();
        idle(4);
        test_back_pressure();
        idle(4);
        test_push_pop();
        idle(4);
        test_reset_mid_stream();
        idle(4);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
